// File: rtl/inst_cache.sv
// Direct-mapped instruction cache sitting between the Fetcher and the MemCtrl fetch port.
// Latency: a hit answers 1 cycle after the request; a miss answers 1 cycle after MemCtrl's word.
// Backpressure: rdy=0 freezes every flop, so state, outputs and counters all hold.
//
// Optional feature macro: ICACHE_STATS_EN. When it is defined, the hit_cnt and miss_cnt
// ports exist. When it is not defined, those ports and their counters are absent.
//
// Ports
//   clk, rst (async, active-low), rdy (global freeze when low)
//   Fetcher side : pc_from_if, ena_from_if, drop_flag_from_if -> ok_flag_to_if, inst_to_if
//   MemCtrl side : pc_to_mc, ena_to_mc, drop_flag_to_mc <- ok_flag_from_mc, inst_from_mc
//   ROB          : rollback_flag_from_rob (aborts a pending response or miss)
//   Stats        : hit_cnt, miss_cnt (only with ICACHE_STATS_EN)
module inst_cache #(
   parameter int INDEX_BITS = 8,
   parameter int ADDR_BITS  = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] pc_from_if,
   input  logic        ena_from_if,
   input  logic        drop_flag_from_if,
   output logic        ok_flag_to_if,
   output logic [31:0] inst_to_if,
   output logic [31:0] pc_to_mc,
   output logic        ena_to_mc,
   output logic        drop_flag_to_mc,
   input  logic        ok_flag_from_mc,
   input  logic [31:0] inst_from_mc,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
`endif
   input  logic        rollback_flag_from_rob
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MISS = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                ok_q, ok_d;
   logic [31:0]         inst_q, inst_d;
   logic [31:0]         pc_mc_q, pc_mc_d;
   logic                ena_mc_q, ena_mc_d;
   logic                drop_mc_q, drop_mc_d;
   logic [LINES-1:0]    valid_q, valid_d;

   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  hit;
   logic                  abort;
   logic                  fill_en;
   logic                  hit_evt;
   logic                  miss_evt;

   // The PC bits above the cached address space and the byte offset take no part in lookup.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_from_if[31:ADDR_BITS], pc_from_if[1:0]};

   assign req_idx = pc_from_if[INDEX_BITS+1:2];
   assign req_tag = pc_from_if[ADDR_BITS-1:INDEX_BITS+2];

   // pc_to_mc holds the missing address for the whole MISS period, so it also serves
   // as the fill address. No separate latch is needed.
   assign fill_idx = pc_mc_q[INDEX_BITS+1:2];
   assign fill_tag = pc_mc_q[ADDR_BITS-1:INDEX_BITS+2];

   assign hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign abort = rollback_flag_from_rob || drop_flag_from_if;

   always_comb begin
      state_d   = state_q;
      ok_d      = ok_q;
      inst_d    = inst_q;
      pc_mc_d   = pc_mc_q;
      ena_mc_d  = ena_mc_q;
      drop_mc_d = drop_mc_q;
      fill_en   = 1'b0;
      hit_evt   = 1'b0;
      miss_evt  = 1'b0;

      if (rdy) begin
         // Pulse outputs last for a single active cycle.
         ok_d      = 1'b0;
         ena_mc_d  = 1'b0;
         drop_mc_d = 1'b0;

         case (state_q)
            S_IDLE: begin
               // An abort in the request cycle wins and the request is dropped.
               // In that case, no response is generated and no miss is issued.
               if (!abort && ena_from_if) begin
                  if (hit) begin
                     ok_d    = 1'b1;
                     inst_d  = data_mem[req_idx];
                     hit_evt = 1'b1;
                  end else begin
                     ena_mc_d = 1'b1;
                     pc_mc_d  = pc_from_if;
                     state_d  = S_MISS;
                     miss_evt = 1'b1;
                  end
               end
            end
            S_MISS: begin
               // New requests are ignored here because the fetcher has only one request outstanding.
               // An abort also discards a word that MemCtrl returns in the same cycle.
               if (abort) begin
                  drop_mc_d = 1'b1;
                  state_d   = S_IDLE;
               end else if (ok_flag_from_mc) begin
                  fill_en = 1'b1;
                  ok_d    = 1'b1;
                  inst_d  = inst_from_mc;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (fill_en) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ok_q      <= 1'b0;
         inst_q    <= 32'd0;
         pc_mc_q   <= 32'd0;
         ena_mc_q  <= 1'b0;
         drop_mc_q <= 1'b0;
         valid_q   <= '0;
      end else begin
         state_q   <= state_d;
         ok_q      <= ok_d;
         inst_q    <= inst_d;
         pc_mc_q   <= pc_mc_d;
         ena_mc_q  <= ena_mc_d;
         drop_mc_q <= drop_mc_d;
         valid_q   <= valid_d;
      end
   end

   // The tag and data arrays are gated by valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= inst_from_mc;
      end
   end

   assign ok_flag_to_if   = ok_q;
   assign inst_to_if      = inst_q;
   assign pc_to_mc        = pc_mc_q;
   assign ena_to_mc       = ena_mc_q;
   assign drop_flag_to_mc = drop_mc_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // hit_evt and miss_evt are only raised while rdy=1, so the counters hold under freeze.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_evt) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (miss_evt) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic [31:0] pc_from_if;
   logic        ena_from_if;
   logic        drop_flag_from_if;
   logic        ok_flag_to_if;
   logic [31:0] inst_to_if;
   logic [31:0] pc_to_mc;
   logic        ena_to_mc;
   logic        drop_flag_to_mc;
   logic        ok_flag_from_mc;
   logic [31:0] inst_from_mc;
   logic        rollback_flag_from_rob;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   inst_cache #(.INDEX_BITS(8), .ADDR_BITS(18)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .rdy                    (rdy),
      .pc_from_if             (pc_from_if),
      .ena_from_if            (ena_from_if),
      .drop_flag_from_if      (drop_flag_from_if),
      .ok_flag_to_if          (ok_flag_to_if),
      .inst_to_if             (inst_to_if),
      .pc_to_mc               (pc_to_mc),
      .ena_to_mc              (ena_to_mc),
      .drop_flag_to_mc        (drop_flag_to_mc),
      .ok_flag_from_mc        (ok_flag_from_mc),
      .inst_from_mc           (inst_from_mc),
`ifdef ICACHE_STATS_EN
      .hit_cnt                (hit_cnt),
      .miss_cnt               (miss_cnt),
`endif
      .rollback_flag_from_rob (rollback_flag_from_rob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;

   exp_t q_if[$];
   exp_t q_mc[$];
   exp_t q_drop[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: each pulse output is popped and compared against its queue (value and cycle).
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (ok_flag_to_if) begin
            total++;
            if (q_if.size() == 0) begin
               bad++;
               $display("FAIL if_resp unexpected: inst=%h at cyc %0d, required no response", inst_to_if, cyc);
            end else begin
               e = q_if.pop_front();
               if (inst_to_if !== e.val || cyc != e.cyc) begin
                  bad++;
                  $display("FAIL if_resp: inst=%h cyc=%0d, required inst=%h cyc=%0d", inst_to_if, cyc, e.val, e.cyc);
               end
            end
         end
         if (ena_to_mc) begin
            total++;
            if (q_mc.size() == 0) begin
               bad++;
               $display("FAIL mc_req unexpected: pc=%h at cyc %0d, required no request", pc_to_mc, cyc);
            end else begin
               e = q_mc.pop_front();
               if (pc_to_mc !== e.val || cyc != e.cyc) begin
                  bad++;
                  $display("FAIL mc_req: pc=%h cyc=%0d, required pc=%h cyc=%0d", pc_to_mc, cyc, e.val, e.cyc);
               end
            end
         end
         if (drop_flag_to_mc) begin
            total++;
            if (q_drop.size() == 0) begin
               bad++;
               $display("FAIL mc_drop unexpected at cyc %0d, required no drop", cyc);
            end else begin
               e = q_drop.pop_front();
               if (cyc != e.cyc) begin
                  bad++;
                  $display("FAIL mc_drop: cyc=%0d, required cyc=%0d", cyc, e.cyc);
               end
            end
         end
      end
   end

   // The fetch is driven right after a posedge and is sampled at the next edge, so any output appears at cyc+1.
   task automatic fetch(input logic [31:0] pc, input bit expect_hit, input logic [31:0] inst);
      pc_from_if  = pc;
      ena_from_if = 1'b1;
      if (expect_hit) q_if.push_back('{inst, cyc + 1});
      else            q_mc.push_back('{pc, cyc + 1});
      @(posedge clk); #1;
      ena_from_if = 1'b0;
   endtask

   // MemCtrl model: the word is returned two cycles after the request is observed.
   task automatic mc_return(input logic [31:0] inst);
      repeat (2) @(posedge clk);
      #1;
      ok_flag_from_mc = 1'b1;
      inst_from_mc    = inst;
      q_if.push_back('{inst, cyc + 1});
      @(posedge clk); #1;
      ok_flag_from_mc = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; rdy = 1'b1;
      pc_from_if = 32'd0; ena_from_if = 1'b0; drop_flag_from_if = 1'b0;
      ok_flag_from_mc = 1'b0; inst_from_mc = 32'd0; rollback_flag_from_rob = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ok",   {31'd0, ok_flag_to_if},   32'd0);
      chk("rst_inst", inst_to_if,               32'd0);
      chk("rst_pcmc", pc_to_mc,                 32'd0);
      chk("rst_ena",  {31'd0, ena_to_mc},       32'd0);
      chk("rst_drop", {31'd0, drop_flag_to_mc}, 32'd0);
      rst = 1'b1;
      idle(2);

      // Cold miss on 0x0000, followed by two hits.
      fetch(32'h0000_0000, 1'b0, 32'h0);
      mc_return(32'h0000_0013);
      idle(2);
      fetch(32'h0000_0000, 1'b1, 32'h0000_0013);
      idle(1);
      fetch(32'h0000_0000, 1'b1, 32'h0000_0013);
      idle(2);

      // 0x0400 and 0x0000 share index 0 but have different tags, so they evict each other.
      fetch(32'h0000_0400, 1'b0, 32'h0);
      mc_return(32'h1234_5678);
      idle(2);
      fetch(32'h0000_0000, 1'b0, 32'h0);
      mc_return(32'h0000_0013);
      idle(3);
`ifdef ICACHE_STATS_EN
      chk("hit_cnt",  hit_cnt,  32'd2);
      chk("miss_cnt", miss_cnt, 32'd3);
`endif

      // A rollback during a miss drops the request. The word arriving in that same cycle is discarded.
      fetch(32'h0000_0010, 1'b0, 32'h0);
      rollback_flag_from_rob = 1'b1;
      ok_flag_from_mc = 1'b1;
      inst_from_mc    = 32'hDEAD_BEEF;
      q_drop.push_back('{32'd0, cyc + 1});
      @(posedge clk); #1;
      rollback_flag_from_rob = 1'b0;
      ok_flag_from_mc = 1'b0;
      idle(3);
      fetch(32'h0000_0010, 1'b0, 32'h0);
      mc_return(32'hAABB_CCDD);
      idle(2);

      // An abort in the same cycle as a hitting request suppresses the response.
      rollback_flag_from_rob = 1'b1;
      fetch(32'h0000_0010, 1'b1, 32'h0);
      void'(q_if.pop_back());
      rollback_flag_from_rob = 1'b0;
      drop_flag_from_if = 1'b1;
      fetch(32'h0000_0010, 1'b1, 32'h0);
      void'(q_if.pop_back());
      drop_flag_from_if = 1'b0;
      idle(3);

      // A hit request held while rdy is low is only served once rdy returns.
      rdy = 1'b0;
      pc_from_if  = 32'h0000_0010;
      ena_from_if = 1'b1;
      idle(5);
      rdy = 1'b1;
      q_if.push_back('{32'hAABB_CCDD, cyc + 1});
      @(posedge clk); #1;
      ena_from_if = 1'b0;
      idle(2);

      // An asynchronous reset in the middle of a miss clears the outputs immediately.
      fetch(32'h0000_0020, 1'b0, 32'h0);
      idle(1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ok",   {31'd0, ok_flag_to_if},   32'd0);
      chk("arst_inst", inst_to_if,               32'd0);
      chk("arst_pcmc", pc_to_mc,                 32'd0);
      chk("arst_ena",  {31'd0, ena_to_mc},       32'd0);
      chk("arst_drop", {31'd0, drop_flag_to_mc}, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("arst_hit_cnt",  hit_cnt,  32'd0);
      chk("arst_miss_cnt", miss_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2);
      fetch(32'h0000_0000, 1'b0, 32'h0);
      mc_return(32'h0000_0013);
      idle(3);

      chk("leftover_if",   q_if.size(),   32'd0);
      chk("leftover_mc",   q_mc.size(),   32'd0);
      chk("leftover_drop", q_drop.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
